mux_32: RTL and testbench

Parameterized 32-to-1 multiplexer of N-bit words, selected by a 5-bit index. It is a generic datapath building block, such as register-file read ports or operand selection. The default configuration is purely combinational. An optional output register stage, clocked by `clk` with synchronous reset, can be enabled by parameter.

---
 rtl/mux_32_pkg.sv | 18 +
 rtl/mux_32_mux2.sv | 25 ++
 rtl/mux_32.sv | 131 +++++++++++++
 tb/tb_mux_32.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mux_32_pkg.sv
// mux_32_pkg: shared sizing constants for the 32:1 word multiplexer tree.
// The select width and the tree depth both follow from the input count,
// so changing the fan-in only touches NumInputs.
package mux_32_pkg;

    localparam int unsigned NumInputs  = 32;
    localparam int unsigned SelWidth   = $clog2(NumInputs);
    localparam int unsigned TreeLevels = SelWidth;

    // Index of the first node of a tree level when the tree is stored as a
    // heap: node 1 is the root, the children of node i are 2i and 2i+1, and
    // the leaves (the data inputs) occupy NumInputs .. 2*NumInputs-1.
    // Level 0 is the leaf-side mux level, steered by select[0].
    function automatic int unsigned levelBase(input int unsigned level);
        return NumInputs >> (level + 1);
    endfunction

endpackage

// File: rtl/mux_32_mux2.sv
// mux2: N-bit 2:1 multiplexer, the single building block of the mux_32 tree.
// An unknown select drives X onto the output so that simulation exposes an
// undriven or corrupted index instead of silently merging the two inputs.
module mux2
    import mux_32_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic [N-1:0] in0_i,
    input  logic [N-1:0] in1_i,
    input  logic         sel_i,
    output logic [N-1:0] out_o
);

    // Pick one of the two words; any non-0/1 select value yields X.
    always_comb begin
        out_o = 'x;
        case (sel_i)
            1'b0:    out_o = in0_i;
            1'b1:    out_o = in1_i;
            default: out_o = 'x;
        endcase
    end

endmodule

// File: rtl/mux_32.sv
// mux_32: 32-to-1 multiplexer of N-bit words built as a balanced binary tree
// of mux2 cells. select[0] steers the leaf level and select[4] the root.
// With REGISTERED=1 the root is captured in an output register that has a
// synchronous active-high reset; otherwise the path is purely combinational
// and clk/rst are ignored.
module mux_32
    import mux_32_pkg::*;
#(
    parameter int unsigned N          = 1,
    parameter bit          REGISTERED = 1'b0
) (
    input  logic [N-1:0]          in00,
    input  logic [N-1:0]          in01,
    input  logic [N-1:0]          in02,
    input  logic [N-1:0]          in03,
    input  logic [N-1:0]          in04,
    input  logic [N-1:0]          in05,
    input  logic [N-1:0]          in06,
    input  logic [N-1:0]          in07,
    input  logic [N-1:0]          in08,
    input  logic [N-1:0]          in09,
    input  logic [N-1:0]          in10,
    input  logic [N-1:0]          in11,
    input  logic [N-1:0]          in12,
    input  logic [N-1:0]          in13,
    input  logic [N-1:0]          in14,
    input  logic [N-1:0]          in15,
    input  logic [N-1:0]          in16,
    input  logic [N-1:0]          in17,
    input  logic [N-1:0]          in18,
    input  logic [N-1:0]          in19,
    input  logic [N-1:0]          in20,
    input  logic [N-1:0]          in21,
    input  logic [N-1:0]          in22,
    input  logic [N-1:0]          in23,
    input  logic [N-1:0]          in24,
    input  logic [N-1:0]          in25,
    input  logic [N-1:0]          in26,
    input  logic [N-1:0]          in27,
    input  logic [N-1:0]          in28,
    input  logic [N-1:0]          in29,
    input  logic [N-1:0]          in30,
    input  logic [N-1:0]          in31,
    input  logic [SelWidth-1:0]   select,
    output logic [N-1:0]          out,
    input  logic                  clk,
    input  logic                  rst
);

    // Heap-ordered tree storage: node[1] is the root, node[32..63] are the
    // data inputs, and every node in between is the output of one mux2.
    logic [N-1:0] node [1:2*NumInputs-1];

    assign node[NumInputs + 0]  = in00;
    assign node[NumInputs + 1]  = in01;
    assign node[NumInputs + 2]  = in02;
    assign node[NumInputs + 3]  = in03;
    assign node[NumInputs + 4]  = in04;
    assign node[NumInputs + 5]  = in05;
    assign node[NumInputs + 6]  = in06;
    assign node[NumInputs + 7]  = in07;
    assign node[NumInputs + 8]  = in08;
    assign node[NumInputs + 9]  = in09;
    assign node[NumInputs + 10] = in10;
    assign node[NumInputs + 11] = in11;
    assign node[NumInputs + 12] = in12;
    assign node[NumInputs + 13] = in13;
    assign node[NumInputs + 14] = in14;
    assign node[NumInputs + 15] = in15;
    assign node[NumInputs + 16] = in16;
    assign node[NumInputs + 17] = in17;
    assign node[NumInputs + 18] = in18;
    assign node[NumInputs + 19] = in19;
    assign node[NumInputs + 20] = in20;
    assign node[NumInputs + 21] = in21;
    assign node[NumInputs + 22] = in22;
    assign node[NumInputs + 23] = in23;
    assign node[NumInputs + 24] = in24;
    assign node[NumInputs + 25] = in25;
    assign node[NumInputs + 26] = in26;
    assign node[NumInputs + 27] = in27;
    assign node[NumInputs + 28] = in28;
    assign node[NumInputs + 29] = in29;
    assign node[NumInputs + 30] = in30;
    assign node[NumInputs + 31] = in31;

    // One mux2 per internal node. Level lvl halves the candidate set using
    // select[lvl]; even-indexed children are taken when that bit is 0, which
    // keeps inK at index K all the way to the root.
    for (genvar lvl = 0; lvl < TreeLevels; lvl++) begin : gLevel
        for (genvar j = 0; j < int'(levelBase(lvl)); j++) begin : gNode
            localparam int unsigned Idx = levelBase(lvl) + j;

            mux2 #(
                .N (N)
            ) uMux (
                .in0_i (node[2*Idx]),
                .in1_i (node[2*Idx+1]),
                .sel_i (select[lvl]),
                .out_o (node[Idx])
            );
        end
    end

    logic [N-1:0] out_d;

    assign out_d = node[1];

    if (REGISTERED) begin : gReg
        logic [N-1:0] out_q;

        // Output register: reset wins over data on the same edge, and the
        // value is X until the first rising edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
            end else begin
                out_q <= out_d;
            end
        end

        assign out = out_q;
    end else begin : gComb
        // clk and rst exist only for a uniform port list in this mode.
        logic unusedClkRst;

        assign unusedClkRst = clk ^ rst;
        assign out          = out_d;
    end

endmodule

// File: tb/tb_mux_32.sv
// tb_mux_32: directed bench for mux_32. Three instances are exercised:
// a 1-bit combinational mux, an 8-bit combinational mux and an 8-bit
// registered mux; the two 8-bit instances share their data and select.
module tb_mux_32;

    logic       clk;
    logic       rst;
    logic       bits1 [32];
    logic [4:0] sel1;
    logic       out1;
    logic [7:0] d8 [32];
    logic [4:0] sel8;
    logic [7:0] out8;
    logic [7:0] outR;

    int vectors;
    int miscompares;

    mux_32 #(.N(1), .REGISTERED(1'b0)) uComb1 (
        .in00(bits1[0]),  .in01(bits1[1]),  .in02(bits1[2]),  .in03(bits1[3]),
        .in04(bits1[4]),  .in05(bits1[5]),  .in06(bits1[6]),  .in07(bits1[7]),
        .in08(bits1[8]),  .in09(bits1[9]),  .in10(bits1[10]), .in11(bits1[11]),
        .in12(bits1[12]), .in13(bits1[13]), .in14(bits1[14]), .in15(bits1[15]),
        .in16(bits1[16]), .in17(bits1[17]), .in18(bits1[18]), .in19(bits1[19]),
        .in20(bits1[20]), .in21(bits1[21]), .in22(bits1[22]), .in23(bits1[23]),
        .in24(bits1[24]), .in25(bits1[25]), .in26(bits1[26]), .in27(bits1[27]),
        .in28(bits1[28]), .in29(bits1[29]), .in30(bits1[30]), .in31(bits1[31]),
        .select(sel1), .out(out1), .clk(clk), .rst(rst)
    );

    mux_32 #(.N(8), .REGISTERED(1'b0)) uComb8 (
        .in00(d8[0]),  .in01(d8[1]),  .in02(d8[2]),  .in03(d8[3]),
        .in04(d8[4]),  .in05(d8[5]),  .in06(d8[6]),  .in07(d8[7]),
        .in08(d8[8]),  .in09(d8[9]),  .in10(d8[10]), .in11(d8[11]),
        .in12(d8[12]), .in13(d8[13]), .in14(d8[14]), .in15(d8[15]),
        .in16(d8[16]), .in17(d8[17]), .in18(d8[18]), .in19(d8[19]),
        .in20(d8[20]), .in21(d8[21]), .in22(d8[22]), .in23(d8[23]),
        .in24(d8[24]), .in25(d8[25]), .in26(d8[26]), .in27(d8[27]),
        .in28(d8[28]), .in29(d8[29]), .in30(d8[30]), .in31(d8[31]),
        .select(sel8), .out(out8), .clk(clk), .rst(rst)
    );

    mux_32 #(.N(8), .REGISTERED(1'b1)) uReg8 (
        .in00(d8[0]),  .in01(d8[1]),  .in02(d8[2]),  .in03(d8[3]),
        .in04(d8[4]),  .in05(d8[5]),  .in06(d8[6]),  .in07(d8[7]),
        .in08(d8[8]),  .in09(d8[9]),  .in10(d8[10]), .in11(d8[11]),
        .in12(d8[12]), .in13(d8[13]), .in14(d8[14]), .in15(d8[15]),
        .in16(d8[16]), .in17(d8[17]), .in18(d8[18]), .in19(d8[19]),
        .in20(d8[20]), .in21(d8[21]), .in22(d8[22]), .in23(d8[23]),
        .in24(d8[24]), .in25(d8[25]), .in26(d8[26]), .in27(d8[27]),
        .in28(d8[28]), .in29(d8[29]), .in30(d8[30]), .in31(d8[31]),
        .select(sel8), .out(outR), .clk(clk), .rst(rst)
    );

    // Free-running 10 ns clock for the registered instance.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one registered-path step just after a falling edge.
    task automatic applyStimulus(input logic [4:0] sel, input logic rstVal);
        @(negedge clk);
        sel8 = sel;
        rst  = rstVal;
    endtask

    task automatic loadUnique();
        for (int k = 0; k < 32; k++) d8[k] = 8'(k) + 8'h40;
    endtask

    // Directed sequence: walking bits, unique words, fixed select, then the
    // registered reset/latency and mid-stream reset checks.
    initial begin
        logic [31:0] walkMask;
        logic        expBit;
        logic [7:0]  expWord;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        sel1        = '0;
        sel8        = '0;

        walkMask = 32'h8104_2225;
        for (int k = 0; k < 32; k++) bits1[k] = walkMask[k];
        for (int s = 0; s < 32; s++) begin
            sel1 = s[4:0];
            #1;
            expBit = (s inside {0, 2, 5, 9, 13, 18, 24, 31}) ? 1'b1 : 1'b0;
            checkOutput($sformatf("walk1[%0d]", s), {7'd0, out1}, {7'd0, expBit});
        end

        loadUnique();
        for (int s = 0; s < 32; s++) begin
            sel8 = s[4:0];
            #1;
            checkOutput($sformatf("unique8[%0d]", s), out8, 8'(s) + 8'h40);
        end

        sel8 = 5'd17;
        for (int i = 0; i < 8; i++) begin
            expWord = (i % 2 == 0) ? 8'hA5 : 8'h5A;
            for (int k = 0; k < 32; k++) d8[k] = 8'($urandom_range(0, 255));
            d8[17] = expWord;
            #1;
            checkOutput($sformatf("fixedSel17[%0d]", i), out8, expWord);
        end

        loadUnique();
        applyStimulus(5'd5, 1'b0);
        @(posedge clk); #1;
        checkOutput("regLoad", outR, 8'h45);

        applyStimulus(5'd5, 1'b1);
        @(posedge clk); #1;
        checkOutput("regReset", outR, 8'h00);

        applyStimulus(5'd3, 1'b0);
        d8[3] = 8'h3C;
        #1;
        checkOutput("regHoldBeforeEdge", outR, 8'h00);
        @(posedge clk); #1;
        checkOutput("regRelease", outR, 8'h3C);

        d8[3] = 8'h43;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(5'(i), (i == 5) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
            expWord = (i == 5) ? 8'h00 : 8'(i) + 8'h40;
            checkOutput($sformatf("midStream[%0d]", i), outR, expWord);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
